// File: rtl/uart_tx.sv
// Byte-wide UART transmitter: 8 data bits LSB first, optional even/odd parity, one stop bit,
// with a one-byte holding buffer so consecutive frames go out with no idle gap.
module uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY       = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] din,
  input  logic       wr,
  output logic       tx_rdy,
  output logic       busy,
  output logic       done,
  output logic       txd
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4
  } state_t;

  localparam logic [15:0] BAUD_MAX = 16'(CLKS_PER_BIT - 1);
  localparam logic        HAS_PAR  = (PARITY != 0);
  localparam logic        ODD_PAR  = (PARITY == 2);

  function automatic logic parity_bit(input logic [7:0] data, input logic odd);
    parity_bit = (^data) ^ odd;
  endfunction

  state_t      state_r, state_s;
  logic [15:0] baud_r, baud_s;
  logic [2:0]  bit_r, bit_s;
  logic [7:0]  shift_r, shift_s;
  logic [7:0]  hold_r, hold_s;
  logic        full_r, full_s;
  logic        txd_r, txd_s;
  logic        done_r, done_s;
  logic        bit_end_s;

  // Next-state, datapath and output-register values for the transmitter.
  always_comb begin
    state_s   = state_r;
    baud_s    = baud_r;
    bit_s     = bit_r;
    shift_s   = shift_r;
    hold_s    = hold_r;
    full_s    = full_r;
    txd_s     = txd_r;
    done_s    = 1'b0;
    bit_end_s = (baud_r == BAUD_MAX);

    // A write can only land while the buffer is empty, so it never races a transfer.
    if (wr && !full_r) begin
      full_s = 1'b1;
      hold_s = din;
    end else begin
      full_s = full_r;
    end

    case (state_r)
      IDLE: begin
        if (full_r) begin
          state_s = START;
          shift_s = hold_r;
          full_s  = 1'b0;
          baud_s  = 16'd0;
          txd_s   = 1'b0;
        end else begin
          baud_s  = 16'd0;
          txd_s   = 1'b1;
        end
      end
      START: begin
        if (bit_end_s) begin
          state_s = DATA;
          baud_s  = 16'd0;
          txd_s   = shift_r[0];
        end else begin
          baud_s  = baud_r + 16'd1;
        end
      end
      DATA: begin
        if (bit_end_s) begin
          baud_s = 16'd0;
          if (bit_r == 3'd7) begin
            bit_s = 3'd0;
            if (HAS_PAR) begin
              state_s = PAR;
              txd_s   = parity_bit(shift_r, ODD_PAR);
            end else begin
              state_s = STOP;
              txd_s   = 1'b1;
            end
          end else begin
            bit_s = bit_r + 3'd1;
            txd_s = shift_r[bit_r + 3'd1];
          end
        end else begin
          baud_s = baud_r + 16'd1;
        end
      end
      PAR: begin
        if (bit_end_s) begin
          state_s = STOP;
          baud_s  = 16'd0;
          txd_s   = 1'b1;
        end else begin
          baud_s  = baud_r + 16'd1;
        end
      end
      STOP: begin
        if (bit_end_s) begin
          done_s = 1'b1;
          baud_s = 16'd0;
          if (full_r) begin
            state_s = START;
            shift_s = hold_r;
            full_s  = 1'b0;
            txd_s   = 1'b0;
          end else begin
            state_s = IDLE;
            txd_s   = 1'b1;
          end
        end else begin
          baud_s = baud_r + 16'd1;
        end
      end
      default: begin
        state_s = IDLE;
        baud_s  = 16'd0;
        bit_s   = 3'd0;
        txd_s   = 1'b1;
      end
    endcase
  end

  // State and datapath registers; reset aborts any frame and empties the buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      baud_r  <= 16'd0;
      bit_r   <= 3'd0;
      shift_r <= 8'd0;
      hold_r  <= 8'd0;
      full_r  <= 1'b0;
      txd_r   <= 1'b1;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      baud_r  <= baud_s;
      bit_r   <= bit_s;
      shift_r <= shift_s;
      hold_r  <= hold_s;
      full_r  <= full_s;
      txd_r   <= txd_s;
      done_r  <= done_s;
    end
  end

  assign tx_rdy = ~full_r;
  assign busy   = (state_r != IDLE);
  assign done   = done_r;
  assign txd    = txd_r;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: table of single frames across parity modes, back-to-back and
// ignored-write sequences, mid-frame reset, and a 256-byte loopback through a sampling receiver.
module tb_uart_tx;

  logic       clk;
  logic       rst_n;
  logic [7:0] din;
  logic [3:0] wr_v, rdy_v, busy_v, done_v, txd_v;
  int         errors = 0;
  int         checks = 0;
  int         cpb_of [4] = '{16, 16, 16, 4};

  typedef struct {
    int         sel;
    logic [7:0] data;
    logic       pbit;
    int         len;
  } vec_t;

  uart_tx #(.CLKS_PER_BIT(16), .PARITY(0)) u0 (.clk(clk), .rst_n(rst_n), .din(din), .wr(wr_v[0]),
    .tx_rdy(rdy_v[0]), .busy(busy_v[0]), .done(done_v[0]), .txd(txd_v[0]));
  uart_tx #(.CLKS_PER_BIT(16), .PARITY(1)) u1 (.clk(clk), .rst_n(rst_n), .din(din), .wr(wr_v[1]),
    .tx_rdy(rdy_v[1]), .busy(busy_v[1]), .done(done_v[1]), .txd(txd_v[1]));
  uart_tx #(.CLKS_PER_BIT(16), .PARITY(2)) u2 (.clk(clk), .rst_n(rst_n), .din(din), .wr(wr_v[2]),
    .tx_rdy(rdy_v[2]), .busy(busy_v[2]), .done(done_v[2]), .txd(txd_v[2]));
  uart_tx #(.CLKS_PER_BIT(4), .PARITY(0)) u3 (.clk(clk), .rst_n(rst_n), .din(din), .wr(wr_v[3]),
    .tx_rdy(rdy_v[3]), .busy(busy_v[3]), .done(done_v[3]), .txd(txd_v[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic frame_bit(input logic [7:0] d, input int k, input int nbits, input logic pbit);
    if (k == 0) return 1'b0;
    else if (k <= 8) return d[k-1];
    else if (k == 9 && nbits == 11) return pbit;
    else return 1'b1;
  endfunction

  // Call at an idle negedge; returns at the negedge of the first start-bit cycle.
  task automatic send(input int sel, input logic [7:0] d);
    din = d;
    wr_v[sel] = 1'b1;
    @(negedge clk);
    wr_v[sel] = 1'b0;
    chk("accept_rdy", rdy_v[sel], 1'b0);
    chk("accept_txd", txd_v[sel], 1'b1);
    chk("accept_busy", busy_v[sel], 1'b0);
    @(negedge clk);
    chk("start_rdy", rdy_v[sel], 1'b1);
    chk("start_busy", busy_v[sel], 1'b1);
  endtask

  // Checks every cycle of one frame; optional writes injected at frame cycles inj_a/inj_b.
  task automatic run_frame(input int sel, input logic [7:0] d, input int len, input logic pbit,
                           input int inj_a, input logic [7:0] da, input int inj_b, input logic [7:0] db);
    int   nbits;
    int   cyc;
    logic pend;
    nbits = len / cpb_of[sel];
    cyc   = 0;
    pend  = 1'b0;
    for (int k = 0; k < nbits; k++) begin
      for (int c = 0; c < cpb_of[sel]; c++) begin
        chk($sformatf("txd_bit%0d_cyc%0d", k, cyc), txd_v[sel], frame_bit(d, k, nbits, pbit));
        chk("busy_frame", busy_v[sel], 1'b1);
        if (cyc > 0) chk("done_early", done_v[sel], 1'b0);
        chk("rdy_frame", rdy_v[sel], !pend);
        wr_v[sel] = 1'b0;
        if (cyc == inj_a || cyc == inj_b) begin
          din = (cyc == inj_a) ? da : db;
          wr_v[sel] = 1'b1;
          pend = 1'b1;
        end
        cyc++;
        @(negedge clk);
      end
    end
    wr_v[sel] = 1'b0;
  endtask

  task automatic end_idle(input int sel);
    chk("done_pulse", done_v[sel], 1'b1);
    chk("end_txd", txd_v[sel], 1'b1);
    chk("end_busy", busy_v[sel], 1'b0);
    chk("end_rdy", rdy_v[sel], 1'b1);
    @(negedge clk);
    chk("done_one_cycle", done_v[sel], 1'b0);
    for (int i = 0; i < 20; i++) begin
      chk("idle_txd", txd_v[sel], 1'b1);
      chk("idle_busy", busy_v[sel], 1'b0);
      @(negedge clk);
    end
  endtask

  initial begin
    vec_t       tbl [8];
    logic [7:0] b, rx;
    int         t;

    tbl[0] = '{0, 8'h55, 1'b0, 160};
    tbl[1] = '{0, 8'h00, 1'b0, 160};
    tbl[2] = '{0, 8'h80, 1'b0, 160};
    tbl[3] = '{1, 8'h07, 1'b1, 176};
    tbl[4] = '{2, 8'h07, 1'b0, 176};
    tbl[5] = '{1, 8'h80, 1'b1, 176};
    tbl[6] = '{2, 8'h55, 1'b1, 176};
    tbl[7] = '{1, 8'hFF, 1'b0, 176};

    rst_n = 1'b0;
    wr_v  = 4'h0;
    din   = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_txd", txd_v, 4'hF);
    chk("rst_rdy", rdy_v, 4'hF);
    chk("rst_busy", busy_v, 4'h0);
    chk("rst_done", done_v, 4'h0);

    // First write lands on the very first edge after reset release.
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(tbl[i].sel, tbl[i].data);
      run_frame(tbl[i].sel, tbl[i].data, tbl[i].len, tbl[i].pbit, -1, 8'h00, -1, 8'h00);
      end_idle(tbl[i].sel);
    end

    // Back-to-back frames; a third write while the buffer is full is dropped.
    send(0, 8'hA5);
    run_frame(0, 8'hA5, 160, 1'b0, 0, 8'h3C, 50, 8'hEE);
    chk("b2b_done", done_v[0], 1'b1);
    chk("b2b_start", txd_v[0], 1'b0);
    chk("b2b_busy", busy_v[0], 1'b1);
    chk("b2b_rdy", rdy_v[0], 1'b1);
    run_frame(0, 8'h3C, 160, 1'b0, -1, 8'h00, -1, 8'h00);
    end_idle(0);

    // Reset at cycle 50 of a frame with a byte waiting in the buffer.
    send(0, 8'h5A);
    for (int c = 0; c < 50; c++) begin
      din = 8'h11;
      wr_v[0] = (c == 10);
      @(negedge clk);
    end
    wr_v[0] = 1'b0;
    chk("pre_rst_txd", txd_v[0], 1'b0);
    chk("pre_rst_rdy", rdy_v[0], 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_txd", txd_v[0], 1'b1);
    chk("mid_rst_rdy", rdy_v[0], 1'b1);
    chk("mid_rst_busy", busy_v[0], 1'b0);
    chk("mid_rst_done", done_v[0], 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("post_rst_txd", txd_v[0], 1'b1);
      chk("post_rst_busy", busy_v[0], 1'b0);
    end
    send(0, 8'hFF);
    run_frame(0, 8'hFF, 160, 1'b0, -1, 8'h00, -1, 8'h00);
    end_idle(0);

    // Loopback: mid-bit sampling receiver at 4 clocks per bit, writes issued during the stop bit.
    for (int n = 0; n < 256; n++) begin
      b = 8'($urandom);
      chk("lb_rdy", rdy_v[3], 1'b1);
      din = b;
      wr_v[3] = 1'b1;
      @(negedge clk);
      wr_v[3] = 1'b0;
      t = 0;
      while (txd_v[3] !== 1'b0 && t < 20) begin
        @(negedge clk);
        t++;
      end
      chk("lb_start_found", (t < 20), 1'b1);
      repeat (2) @(negedge clk);
      chk("lb_start_mid", txd_v[3], 1'b0);
      for (int i = 0; i < 8; i++) begin
        repeat (4) @(negedge clk);
        rx[i] = txd_v[3];
      end
      chk("lb_byte", rx, b);
      repeat (4) @(negedge clk);
      chk("lb_stop", txd_v[3], 1'b1);
    end
    repeat (10) @(negedge clk);
    chk("lb_final_idle", busy_v[3], 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, clk cycles per serial bit (legal range 2..65535).
REQ-002 SHALL have parameter PARITY, default 0, parity mode: 0 none, 1 even, 2 odd.
REQ-003 SHALL have port clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port din  input  8  byte to transmit; sampled only on an accepted write.
REQ-006 SHALL have port wr  input  1  write request; accepted on a rising edge where wr=1 and tx_rdy=1.
REQ-007 SHALL have port tx_rdy  output  1  holding buffer empty; a write may be accepted.
REQ-008 SHALL have port busy  output  1  a frame is on the line (FSM not IDLE).
REQ-009 SHALL have port done  output  1  one-cycle pulse at the end of each stop bit.
REQ-010 SHALL have port txd  output  1  serial line, idle high, registered output.

Function
REQ-011 SHALL frame each byte as: start bit 0, data bits din[0] first through din[7], parity bit only if PARITY!=0, one stop bit 1.
REQ-012 SHALL hold every bit on txd for exactly CLKS_PER_BIT clk cycles, timed by an internal baud counter counting 0..CLKS_PER_BIT-1.
REQ-013 SHALL implement FSM states IDLE, START, DATA, PAR, STOP: IDLE->START when the buffer is full; START->DATA after one bit time; DATA->PAR after the 8th bit if PARITY!=0, else DATA->STOP; PAR->STOP after one bit time; STOP->START if the buffer is full at the end of the stop bit, else STOP->IDLE.
REQ-014 SHALL use a 3-bit data-bit counter that wraps 7->0 on leaving DATA.
REQ-015 SHALL contain a one-byte holding buffer; tx_rdy = buffer empty.
REQ-016 SHALL, on an accepted write at edge E, load din into the buffer and drive tx_rdy=0 from E.
REQ-017 SHALL, when IDLE and the buffer is full at edge E+1, move the buffer into the shift register, restart the baud counter, drive txd=0, and drive tx_rdy=1 and busy=1, all from E+1; latency from accepted wr to the start-bit edge is 1 clk.
REQ-018 SHALL, when the buffer fills during a frame, transfer it at the final cycle of the stop bit so the next start bit follows with zero idle cycles.
REQ-019 SHALL ignore wr while tx_rdy=0, leaving buffer contents unchanged.
REQ-020 SHALL compute the even-parity bit as the XOR of the 8 data bits and the odd-parity bit as its inverse, from the shift-register copy.
REQ-021 SHALL assert done for exactly one cycle, coincident with the edge at which the stop bit ends.
REQ-022 SHALL deassert busy on return to IDLE and keep it high continuously across back-to-back frames.
REQ-023 SHALL, on simultaneous wr acceptance and buffer-to-shift transfer, be impossible by construction (tx_rdy=0 while the buffer is full).

Reset
REQ-024 SHALL, while rst_n=0 and independent of clk, force txd=1, tx_rdy=1, busy=0, done=0, state IDLE, buffer empty, and all counters 0.
REQ-025 SHALL, on reset assertion mid-frame, abort the frame immediately (txd=1 at once) and discard the buffered byte.
REQ-026 SHALL accept a write on the first rising edge after rst_n deasserts.

Verification
REQ-027 SHALL cover: CLKS_PER_BIT=16, PARITY=0, write 0x55 -> txd = 0,1,0,1,0,1,0,1,0,1, each 16 cycles; done pulses at cycle 160; then idle high.
REQ-028 SHALL cover: PARITY=1, write 0x07 -> parity bit 1; PARITY=2, write 0x07 -> parity bit 0; frame length 176 cycles.
REQ-029 SHALL cover: write 0xA5, then 0x3C as soon as tx_rdy rises -> two frames in 320 contiguous cycles, no idle gap, busy high throughout, two done pulses.
REQ-030 SHALL cover: a second and third wr during the 0xA5 frame with the buffer full -> only the first is accepted; the third value never appears on txd.
REQ-031 SHALL cover: rst_n low at cycle 50 of a frame -> txd=1 in the same cycle, tx_rdy=1, busy=0; a fresh write of 0xFF afterwards transmits correctly.
REQ-032 SHALL cover: loopback of txd into the team's UART receiver with bit timing matched, over 256 random bytes -> every byte received equals the byte sent.
